// File: rtl/display_pkg.sv
// Shared display constants: special digit codes understood by the 7-segment
// decoders and the state encoding of the binary-to-BCD converter FSM.
package display_pkg;

   // Digit code that the decoders render as an unlit digit
   localparam logic [3:0] BCD_BLANK = 4'hA;
   // Digit code that the decoders render as "H"
   localparam logic [3:0] BCD_HALT  = 4'hF;

   // Converter FSM encoding
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/ajuste_bcd.sv
// Double-dabble correction for a single BCD digit: a digit of 5 or more
// gets 3 added so that the following left shift carries into the next digit.
module ajuste_bcd (
   input  logic [3:0] digito,
   output logic [3:0] ajustado
);

   assign ajustado = (digito >= 4'd5) ? digito + 4'd3 : digito;

endmodule

// File: rtl/conversor_bin_bcd.sv
// Iterative binary-to-BCD converter (shift-add-3), one bit per clock.
// Produces one 4-bit code per display digit, with optional leading-zero
// blanking (BLANK_ZEROS). Optional macro HALT_DISPLAY_EN adds a registered
// override that shows "H" on every digit while the halt input is high.
module conversor_bin_bcd
   import display_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DIGITS      = 5,
   parameter int BLANK_ZEROS = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      valor,
   input  logic                  halt,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  busy,
   output logic                  done
);

   localparam int CW = $clog2(WIDTH + 1);

   // DIGITS must cover ceil(WIDTH*log10(2)) decimal digits
   if (DIGITS * 100000 < WIDTH * 30103) begin : g_digits_check
      $error("conversor_bin_bcd: DIGITS too small for WIDTH");
   end

   logic [1:0]            state_reg;
   logic [WIDTH-1:0]      shift_reg;
   logic [4*DIGITS-1:0]   acc_reg;
   logic [CW-1:0]         cnt_reg;
   logic [4*DIGITS-1:0]   result_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic [4*DIGITS-1:0]   acc_adj;
   logic [4*DIGITS-1:0]   acc_blanked;

   // One add-3 corrector per accumulator digit
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_ajuste
      ajuste_bcd u_ajuste (
         .digito   (acc_reg[4*gi +: 4]),
         .ajustado (acc_adj[4*gi +: 4])
      );
   end

   // Replace leading zero digits with blank codes; digit 0 always shows
   always_comb begin
      logic lead;
      acc_blanked = acc_reg;
      lead        = 1'b1;
      if (BLANK_ZEROS != 0) begin
         for (int i = DIGITS - 1; i >= 1; i--) begin
            if (lead && acc_reg[4*i +: 4] == 4'd0) begin
               acc_blanked[4*i +: 4] = BCD_BLANK;
            end else begin
               lead = 1'b0;
            end
         end
      end
   end

   // Conversion FSM: capture, shift WIDTH times, publish result
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         shift_reg  <= '0;
         acc_reg    <= '0;
         cnt_reg    <= '0;
         result_reg <= {DIGITS{BCD_BLANK}};
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  shift_reg <= valor;
                  acc_reg   <= '0;
                  cnt_reg   <= CW'(WIDTH);
                  busy_reg  <= 1'b1;
                  state_reg <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               acc_reg   <= {acc_adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
               shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
               cnt_reg   <= cnt_reg - CW'(1);
               if (cnt_reg == CW'(1)) begin
                  busy_reg  <= 1'b0;
                  state_reg <= S_DONE;
               end
            end
            S_DONE: begin
               result_reg <= acc_blanked;
               done_reg   <= 1'b1;
               state_reg  <= S_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_reg;
   assign done = done_reg;

`ifdef HALT_DISPLAY_EN
   logic halt_reg;

   // Registered halt flag so the override appears one cycle after halt rises
   always_ff @(posedge clock) begin
      if (reset) begin
         halt_reg <= 1'b0;
      end else begin
         halt_reg <= halt;
      end
   end

   assign bcd_out = halt_reg ? {DIGITS{BCD_HALT}} : result_reg;
`else
   logic halt_unused;
   assign halt_unused = halt;
   assign bcd_out     = result_reg;
`endif

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Self-checking bench for conversor_bin_bcd. Two instances share stimulus:
// one with leading-zero blanking, one without. Results are compared against
// a decimal reference computed with plain division. Build with
// HALT_DISPLAY_EN defined to exercise the halt override.
module tb_conversor_bin_bcd;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] valor;
   logic        halt;
   logic [19:0] bcd_b, bcd_z;
   logic        busy_b, busy_z, done_b, done_z;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   conversor_bin_bcd #(.WIDTH(16), .DIGITS(5), .BLANK_ZEROS(1)) u_blank (
      .clock (clock), .reset (reset), .start (start), .valor (valor),
      .halt (halt), .bcd_out (bcd_b), .busy (busy_b), .done (done_b)
   );

   conversor_bin_bcd #(.WIDTH(16), .DIGITS(5), .BLANK_ZEROS(0)) u_zero (
      .clock (clock), .reset (reset), .start (start), .valor (valor),
      .halt (halt), .bcd_out (bcd_z), .busy (busy_z), .done (done_z)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Decimal digits by division, then optional leading-zero blanking
   function automatic logic [19:0] model(input int unsigned v, input bit blank);
      logic [3:0]  d [5];
      logic [19:0] r;
      int unsigned x;
      x = v;
      for (int i = 0; i < 5; i++) begin
         d[i] = 4'(x % 10);
         x    = x / 10;
      end
      if (blank) begin
         for (int i = 4; i >= 1; i--) begin
            if (d[i] != 4'd0) break;
            d[i] = 4'hA;
         end
      end
      r = '0;
      for (int i = 0; i < 5; i++) r[4*i +: 4] = d[i];
      return r;
   endfunction

   // Start a conversion, scramble valor after acceptance, wait for done
   task automatic convert(input logic [15:0] v, output int lat, output int busy_cnt);
      @(negedge clock);
      valor = v;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      valor = 16'($urandom);
      lat      = 0;
      busy_cnt = busy_b ? 1 : 0;
      while (lat < 100) begin
         @(posedge clock);
         #1;
         lat++;
         if (done_b) break;
         if (busy_b) busy_cnt++;
      end
      if (lat >= 100) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic convert_check(input logic [15:0] v, input string tag);
      int lat, bc;
      convert(v, lat, bc);
      chk({tag, "_lat"}, 32'(lat), 32'd17);
      chk({tag, "_done_z"}, {31'd0, done_z}, 32'd1);
      chk({tag, "_busy_in_done"}, {31'd0, busy_b}, 32'd0);
      chk({tag, "_bcd_blank"}, {12'd0, bcd_b}, {12'd0, model(v, 1'b1)});
      chk({tag, "_bcd_zero"}, {12'd0, bcd_z}, {12'd0, model(v, 1'b0)});
      $display("conv valor=%0d bcd_blank=%h bcd_zero=%h lat=%0d busy=%0d",
               v, bcd_b, bcd_z, lat, bc);
      @(posedge clock);
      #1;
      chk({tag, "_done_pulse"}, {31'd0, done_b}, 32'd0);
   endtask

   initial begin
      int lat, bc, dcount;
      logic [19:0] hold_b;
      reset = 1'b1;
      start = 1'b0;
      valor = '0;
      halt  = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_bcd", {12'd0, bcd_b}, 32'hAAAAA);
      chk("rst_busy", {31'd0, busy_b}, 32'd0);
      chk("rst_done", {31'd0, done_b}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      chk("idle_bcd", {12'd0, bcd_b}, 32'hAAAAA);
      chk("idle_busy", {31'd0, busy_b}, 32'd0);
      chk("idle_done", {31'd0, done_b}, 32'd0);

      // Full-scale value: latency and busy duration
      convert(16'd65535, lat, bc);
      chk("max_lat", 32'(lat), 32'd17);
      chk("max_busy", 32'(bc), 32'd16);
      chk("max_bcd", {12'd0, bcd_b}, 32'h65535);
      $display("conv valor=65535 bcd_blank=%h lat=%0d busy=%0d", bcd_b, lat, bc);

      // Blanking on and off
      convert_check(16'd1234, "v1234");
      chk("v1234_exact", {12'd0, bcd_b}, 32'hA1234);
      convert_check(16'd0, "v0");
      chk("v0_exact_b", {12'd0, bcd_b}, 32'hAAAA0);
      chk("v0_exact_z", {12'd0, bcd_z}, 32'h00000);

      // Start while busy is ignored
      @(negedge clock);
      valor = 16'd42;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (4) @(negedge clock);
      valor = 16'd999;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      dcount = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clock);
         if (done_b) dcount++;
      end
      chk("busy_start_done_cnt", 32'(dcount), 32'd1);
      chk("busy_start_bcd", {12'd0, bcd_b}, 32'hAAA42);
      $display("ignored-start test done_count=%0d bcd=%h", dcount, bcd_b);
      convert_check(16'd999, "v999");
      chk("v999_exact", {12'd0, bcd_b}, 32'hAA999);

      // Reset aborts a running conversion
      @(negedge clock);
      valor = 16'd500;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      dcount = 0;
      repeat (7) begin
         @(negedge clock);
         if (done_b) dcount++;
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_bcd", {12'd0, bcd_b}, 32'hAAAAA);
      chk("abort_busy", {31'd0, busy_b}, 32'd0);
      for (int i = 0; i < 25; i++) begin
         @(negedge clock);
         if (done_b) dcount++;
      end
      chk("abort_no_done", 32'(dcount), 32'd0);
      $display("abort test bcd=%h done_count=%0d", bcd_b, dcount);
      convert_check(16'd500, "v500");

      // Halt override
      convert_check(16'd7, "v7");
      hold_b = bcd_b;
      @(negedge clock);
      halt = 1'b1;
      @(posedge clock);
      #1;
`ifdef HALT_DISPLAY_EN
      chk("halt_on", {12'd0, bcd_b}, 32'hFFFFF);
      chk("halt_on_z", {12'd0, bcd_z}, 32'hFFFFF);
`else
      chk("halt_ignored", {12'd0, bcd_b}, {12'd0, hold_b});
`endif
      @(negedge clock);
      halt = 1'b0;
      @(posedge clock);
      #1;
      chk("halt_off", {12'd0, bcd_b}, 32'hAAAA7);
      $display("halt test bcd=%h", bcd_b);

      // Boundaries and random values
      convert_check(16'd9, "v9");
      convert_check(16'd10, "v10");
      convert_check(16'd100, "v100");
      convert_check(16'd9999, "v9999");
      convert_check(16'd10000, "v10000");
      for (int i = 0; i < 25; i++) begin
         convert_check(16'($urandom_range(0, 65535)), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
